floor_request_queue: RTL and testbench
======================================

FLOOR_REQUEST_QUEUE -- requirements
Module: floor_request_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (2..8); the encoding of `count` SHALL change width with it.
REQ-002 Parameter FLOOR_W, default 2, bits per floor code.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 floor_destiny_Input  in  FLOOR_W  floor code of a new request.
REQ-006 request_Valid  in  1  qualifies floor_destiny_Input for one cycle.
REQ-007 beginEndMemory_Flag  in  1  insertion point: 1 = position 0 (front), 0 = after the last entry (back).
REQ-008 actualFloor  in  FLOOR_W  floor where the car currently is.
REQ-009 floorReached_Flag  in  1  one-cycle pulse: car stopped and door cycle complete at actualFloor.
REQ-010 pos0Mem  out  FLOOR_W  head entry (next target floor), registered.
REQ-011 queueEmpty_Flag  out  1  no entries, registered.
REQ-012 queueFull_Flag  out  1  count == DEPTH, registered.
REQ-013 count  out  clog2(DEPTH+1)  number of stored entries, registered.
REQ-014 request_Accepted  out  1  one-cycle pulse: request stored or merged as a duplicate.
REQ-015 request_Dropped  out  1  one-cycle pulse: request rejected because the queue was full.

Function
REQ-016 Storage SHALL be mem[0..DEPTH-1] plus count; valid entries SHALL always be mem[0..count-1], contiguous from position 0.
REQ-017 Pop condition: floorReached_Flag && count>0 && actualFloor==mem[0].
REQ-018 On pop: mem[i] <= mem[i+1] for i < count-1, and count decrements.
REQ-019 floorReached_Flag with a head mismatch, or with the queue empty, SHALL be ignored.
REQ-020 Push front: entries shift up one (mem[i+1] <= mem[i]), mem[0] <= floor_destiny_Input, and count increments.
REQ-021 Push back: mem[count] <= floor_destiny_Input, and count increments.
REQ-022 Duplicate request (floor equal to any entry that remains after this cycle's pop) SHALL leave storage unchanged and pulse request_Accepted.
REQ-023 Full queue with no pop in the same cycle: the request SHALL be discarded, request_Dropped SHALL pulse, and storage SHALL stay unchanged.
REQ-024 Simultaneous pop and push SHALL be processed as pop first, then push applied to the post-pop contents, in the same edge; a full queue therefore accepts the request.
REQ-025 request_Accepted and request_Dropped SHALL assert on the edge following the request_Valid cycle, for exactly one cycle, and never together.
REQ-026 pos0Mem, count and the flags SHALL reflect the updated contents one cycle after the triggering edge, i.e. registered from next-state values.
REQ-027 When empty, pos0Mem SHALL be all-zero and queueEmpty_Flag SHALL be 1.
REQ-028 Stale entries beyond count SHALL never be observable on any output.
REQ-029 count SHALL never exceed DEPTH and never underflow below 0.

Reset
REQ-030 When reset is 1 at a clock edge, count = 0, all mem entries = 0, pos0Mem = 0, queueEmpty_Flag = 1, queueFull_Flag = 0, request_Accepted = 0 and request_Dropped = 0.
REQ-031 Reset SHALL override a push or pop in the same cycle; a reset asserted mid-operation SHALL discard all queued requests.
REQ-032 In the first cycle after reset deasserts, the block SHALL accept a request normally.

Structure
REQ-033 Shared package floor_pkg SHALL hold FLOOR_W, NUM_FLOORS (4), QUEUE_DEPTH (4) and typedef floor_t (FLOOR_W bits); comparator and queue SHALL both use it.
REQ-034 Duplicate detection SHALL sit in sub-module floor_queue_match: inputs are the entries, count, a pop indication and the request floor; the output is a hit flag; it is purely combinational.
REQ-035 The top level SHALL contain only the storage, the shift/insert control and the output registers; the design is expected to be about 150-250 RTL lines.

Verification
REQ-036 Reset, then push back 2, push back 3 -> pos0Mem=2, count=2, two request_Accepted pulses, request_Dropped never asserts.
REQ-037 Queue {2,3}, push front 1 -> contents {1,2,3} and pos0Mem=1 on the following cycle.
REQ-038 Fill to {0,1,2,3}; push 1 -> request_Accepted, count stays 4; with no pop, a request for a floor outside the queue -> request_Dropped, contents unchanged.
REQ-039 Full {2,1,0,3}; actualFloor=2 with floorReached_Flag pulse in the same cycle as push back 2 -> contents {1,0,3,2}, count=4, request_Accepted pulses.
REQ-040 Head=3, actualFloor=1, floorReached_Flag pulse -> no change. Then actualFloor=3 with a pulse -> head advances and count decrements.
REQ-041 Queue of 3 entries, reset asserted during a push -> count=0, queueEmpty_Flag=1, pos0Mem=0 and both pulse outputs stay 0.

Source files
------------

// File: rtl/floor_pkg.sv
// Shared floor/queue definitions for the elevator request path.
//   FLOOR_W     - bits per floor code
//   NUM_FLOORS  - number of served floors
//   QUEUE_DEPTH - default request queue depth
//   floor_t     - floor code type
package floor_pkg;

    localparam int unsigned FLOOR_W     = 2;
    localparam int unsigned NUM_FLOORS  = 4;
    localparam int unsigned QUEUE_DEPTH = 4;

    typedef logic [FLOOR_W-1:0] floor_t;

endpackage : floor_pkg

// File: rtl/floor_queue_match.sv
// Duplicate-request detector (purely combinational).
//   entries - queue storage, entry 0 is the head
//   count   - number of valid entries
//   pop     - head is being removed this cycle, so it no longer counts
//   floor   - requested floor
//   hit     - request matches an entry that survives this cycle
module floor_queue_match #(
    parameter int unsigned DEPTH   = floor_pkg::QUEUE_DEPTH,
    parameter int unsigned FLOOR_W = floor_pkg::FLOOR_W,
    parameter int unsigned CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic [DEPTH-1:0][FLOOR_W-1:0] entries,
    input  logic [CNT_W-1:0]              count,
    input  logic                          pop,
    input  logic [FLOOR_W-1:0]            floor,
    output logic                          hit
);

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if ((CNT_W'(i) < count) && !(pop && (i == 0)) && (entries[i] == floor)) begin
                hit = 1'b1;
            end
        end
    end

endmodule : floor_queue_match

// File: rtl/floor_request_queue.sv
// Elevator floor request queue: ordered target list with front/back insert,
// duplicate merge, and head pop when the car reaches the head floor.
//   clk, reset          - clock, synchronous active-high reset
//   floor_destiny_Input - requested floor, qualified by request_Valid
//   beginEndMemory_Flag - 1 = insert at front, 0 = insert at back
//   actualFloor         - current car floor
//   floorReached_Flag   - car stopped at actualFloor (pops a matching head)
//   pos0Mem             - head entry (0 when empty)
//   queueEmpty_Flag     - no entries
//   queueFull_Flag      - count == DEPTH
//   count               - number of stored entries
//   request_Accepted    - request stored or merged as duplicate
//   request_Dropped     - request rejected, queue full
module floor_request_queue #(
    parameter int unsigned DEPTH   = floor_pkg::QUEUE_DEPTH,
    parameter int unsigned FLOOR_W = floor_pkg::FLOOR_W
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [FLOOR_W-1:0]             floor_destiny_Input,
    input  logic                           request_Valid,
    input  logic                           beginEndMemory_Flag,
    input  logic [FLOOR_W-1:0]             actualFloor,
    input  logic                           floorReached_Flag,
    output logic [FLOOR_W-1:0]             pos0Mem,
    output logic                           queueEmpty_Flag,
    output logic                           queueFull_Flag,
    output logic [$clog2(DEPTH+1)-1:0]     count,
    output logic                           request_Accepted,
    output logic                           request_Dropped
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0][FLOOR_W-1:0] mem_q;
    logic [DEPTH-1:0][FLOOR_W-1:0] mem_p;
    logic [DEPTH-1:0][FLOOR_W-1:0] mem_n;
    logic [CNT_W-1:0]              cnt_p;
    logic [CNT_W-1:0]              cnt_n;
    logic                          pop_c;
    logic                          hit_c;
    logic                          acc_n;
    logic                          drop_n;

    assign pop_c = floorReached_Flag && (count != '0) && (actualFloor == mem_q[0]);

    floor_queue_match #(
        .DEPTH   (DEPTH),
        .FLOOR_W (FLOOR_W),
        .CNT_W   (CNT_W)
    ) u_match (
        .entries (mem_q),
        .count   (count),
        .pop     (pop_c),
        .floor   (floor_destiny_Input),
        .hit     (hit_c)
    );

    // Pop first, then apply any push to the post-pop contents.
    always_comb begin
        mem_p  = mem_q;
        cnt_p  = count;
        mem_n  = mem_q;
        cnt_n  = count;
        acc_n  = 1'b0;
        drop_n = 1'b0;

        if (pop_c) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                mem_p[i] = mem_q[i+1];
            end
            mem_p[DEPTH-1] = '0;
            cnt_p = count - CNT_W'(1);
        end

        mem_n = mem_p;
        cnt_n = cnt_p;

        if (request_Valid) begin
            if (hit_c) begin
                acc_n = 1'b1;
            end else if (cnt_p == CNT_W'(DEPTH)) begin
                drop_n = 1'b1;
            end else begin
                acc_n = 1'b1;
                cnt_n = cnt_p + CNT_W'(1);
                if (beginEndMemory_Flag) begin
                    for (int i = 1; i < int'(DEPTH); i++) begin
                        mem_n[i] = mem_p[i-1];
                    end
                    mem_n[0] = floor_destiny_Input;
                end else begin
                    for (int i = 0; i < int'(DEPTH); i++) begin
                        if (CNT_W'(i) == cnt_p) begin
                            mem_n[i] = floor_destiny_Input;
                        end
                    end
                end
            end
        end
    end

    // Storage and registered outputs, all taken from next-state values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q            <= '0;
            count            <= '0;
            pos0Mem          <= '0;
            queueEmpty_Flag  <= 1'b1;
            queueFull_Flag   <= 1'b0;
            request_Accepted <= 1'b0;
            request_Dropped  <= 1'b0;
        end else begin
            mem_q            <= mem_n;
            count            <= cnt_n;
            pos0Mem          <= (cnt_n != '0) ? mem_n[0] : '0;
            queueEmpty_Flag  <= (cnt_n == '0);
            queueFull_Flag   <= (cnt_n == CNT_W'(DEPTH));
            request_Accepted <= acc_n;
            request_Dropped  <= drop_n;
        end
    end

endmodule : floor_request_queue

// File: tb/tb_floor_request_queue.sv
// Directed bench for floor_request_queue (DEPTH=4, FLOOR_W=3 so that some
// floor codes can lie outside a full queue).
module tb_floor_request_queue;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned FLOOR_W = 3;
    localparam int unsigned CNT_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset;
    logic [FLOOR_W-1:0] floor_destiny_Input;
    logic               request_Valid;
    logic               beginEndMemory_Flag;
    logic [FLOOR_W-1:0] actualFloor;
    logic               floorReached_Flag;
    logic [FLOOR_W-1:0] pos0Mem;
    logic               queueEmpty_Flag;
    logic               queueFull_Flag;
    logic [CNT_W-1:0]   count;
    logic               request_Accepted;
    logic               request_Dropped;

    int checks = 0;
    int errors = 0;

    floor_request_queue #(
        .DEPTH   (DEPTH),
        .FLOOR_W (FLOOR_W)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .floor_destiny_Input (floor_destiny_Input),
        .request_Valid       (request_Valid),
        .beginEndMemory_Flag (beginEndMemory_Flag),
        .actualFloor         (actualFloor),
        .floorReached_Flag   (floorReached_Flag),
        .pos0Mem             (pos0Mem),
        .queueEmpty_Flag     (queueEmpty_Flag),
        .queueFull_Flag      (queueFull_Flag),
        .count               (count),
        .request_Accepted    (request_Accepted),
        .request_Dropped     (request_Dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        request_Valid       = 1'b0;
        floor_destiny_Input = '0;
        beginEndMemory_Flag = 1'b0;
        floorReached_Flag   = 1'b0;
        actualFloor         = '0;
    endtask

    task automatic push(input int fl, input bit front);
        floor_destiny_Input = FLOOR_W'(fl);
        beginEndMemory_Flag = front;
        request_Valid       = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic reach(input int fl);
        actualFloor       = FLOOR_W'(fl);
        floorReached_Flag = 1'b1;
        step();
        idle_inputs();
    endtask

    task automatic chk_state(input string tag, input int c, input int head);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".pos0"},  int'(pos0Mem), head);
        chk({tag, ".empty"}, int'(queueEmpty_Flag), (c == 0) ? 1 : 0);
        chk({tag, ".full"},  int'(queueFull_Flag), (c == int'(DEPTH)) ? 1 : 0);
    endtask

    task automatic chk_pulse(input string tag, input int acc, input int drp);
        chk({tag, ".acc"},  int'(request_Accepted), acc);
        chk({tag, ".drop"}, int'(request_Dropped), drp);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        step();
        step();
        chk_state("reset", 0, 0);
        chk_pulse("reset", 0, 0);

        // First cycle after reset: push back 2, then 3.
        reset = 1'b0;
        push(2, 1'b0);
        chk_state("pb2", 1, 2);
        chk_pulse("pb2", 1, 0);
        push(3, 1'b0);
        chk_state("pb3", 2, 2);
        chk_pulse("pb3", 1, 0);
        step();
        chk_pulse("idle1", 0, 0);

        // Push front 1 -> {1,2,3}.
        push(1, 1'b1);
        chk_state("pf1", 3, 1);
        chk_pulse("pf1", 1, 0);

        // Drain in order, with an ignored mismatched arrival in between.
        reach(1);
        chk_state("pop1", 2, 2);
        reach(3);
        chk_state("mismatch3", 2, 2);
        reach(2);
        chk_state("pop2", 1, 3);
        reach(3);
        chk_state("pop3", 0, 0);
        reach(0);
        chk_state("pop_empty", 0, 0);

        // Fill {0,1,2,3}; duplicate merges, outside floor is dropped.
        push(0, 1'b0);
        push(1, 1'b0);
        push(2, 1'b0);
        push(3, 1'b0);
        chk_state("fill", 4, 0);
        push(1, 1'b0);
        chk_state("dup1", 4, 0);
        chk_pulse("dup1", 1, 0);
        push(5, 1'b1);
        chk_state("drop5", 4, 0);
        chk_pulse("drop5", 0, 1);
        step();
        chk_pulse("idle2", 0, 0);
        reach(0);
        chk_state("after_drop_pop0", 3, 1);

        // Reset during a push with 3 entries queued.
        floor_destiny_Input = 3'd6;
        request_Valid       = 1'b1;
        actualFloor         = 3'd1;
        floorReached_Flag   = 1'b1;
        reset               = 1'b1;
        step();
        chk_state("rst_mid", 0, 0);
        chk_pulse("rst_mid", 0, 0);
        idle_inputs();
        reset = 1'b0;
        step();
        chk_state("rst_after", 0, 0);
        chk_pulse("rst_after", 0, 0);

        // Full {2,1,0,3}; pop 2 together with push back 2 -> {1,0,3,2}.
        push(2, 1'b0);
        push(1, 1'b0);
        push(0, 1'b0);
        push(3, 1'b0);
        chk_state("full2103", 4, 2);
        actualFloor         = 3'd2;
        floorReached_Flag   = 1'b1;
        floor_destiny_Input = 3'd2;
        beginEndMemory_Flag = 1'b0;
        request_Valid       = 1'b1;
        step();
        idle_inputs();
        chk_state("popush", 4, 1);
        chk_pulse("popush", 1, 0);
        reach(1);
        chk_state("pp_pop1", 3, 0);
        reach(0);
        chk_state("pp_pop0", 2, 3);
        reach(3);
        chk_state("pp_pop3", 1, 2);
        reach(2);
        chk_state("pp_pop2", 0, 0);

        // Head=3: arrival at 1 ignored, arrival at 3 pops.
        push(3, 1'b0);
        push(4, 1'b0);
        reach(1);
        chk_state("head3_miss", 2, 3);
        reach(3);
        chk_state("head3_hit", 1, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_floor_request_queue
